// File: rtl/vis_centroid_calc.sv
// vis_centroid_calc: per-frame centroid of a binary mask, divided sequentially after vsync rise.
// Optional CENTROID_MIN_PIXELS_EN rejects objects smaller than MIN_PIXELS.
module vis_centroid_calc #(
  parameter int IMG_H      = 720,
  parameter int IMG_W      = 1280,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        mask_in,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic        found,
  output logic        centroid_valid
);
  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, DONE} state_t;
  state_t state, state_n;
  logic        vsync_d, frame_end, no_obj, obj, gx, gy;
  logic [10:0] x_pos, y_pos;
  logic [31:0] sum_x, sum_y, qx, qy;
  logic [20:0] cnt, dv, rx, ry;
  logic [21:0] tx, ty;
  logic [4:0]  step;
  assign frame_end = vsync & ~vsync_d;
  assign tx = {rx, qx[31]};
  assign ty = {ry, qy[31]};
  assign gx = tx >= {1'b0, dv};
  assign gy = ty >= {1'b0, dv};
`ifdef CENTROID_MIN_PIXELS_EN
  assign no_obj = dv < 21'(MIN_PIXELS);
  logic unused_hsync;
  assign unused_hsync = hsync;
`else
  assign no_obj = dv == '0;
  logic unused_in;
  assign unused_in = hsync ^ MIN_PIXELS[0];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = frame_end ? CHECK : IDLE;
      CHECK:   state_n = no_obj ? DONE : DIVIDE;
      DIVIDE:  state_n = step == 5'd31 ? DONE : DIVIDE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vsync_d        <= 1'b0;
      x_pos          <= '0;
      y_pos          <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      cnt            <= '0;
      qx             <= '0;
      qy             <= '0;
      dv             <= '0;
      rx             <= '0;
      ry             <= '0;
      step           <= '0;
      obj            <= 1'b0;
      x_center       <= '1;
      y_center       <= '1;
      found          <= 1'b0;
      centroid_valid <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (vsync) begin
        x_pos <= '0;
        y_pos <= '0;
      end else if (de) begin
        x_pos <= x_pos == 11'(IMG_W - 1) ? '0 : x_pos + 11'd1;
        if (x_pos == 11'(IMG_W - 1)) y_pos <= y_pos == 11'(IMG_H - 1) ? '0 : y_pos + 11'd1;
      end
      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else if (de && mask_in && !vsync) begin
        sum_x <= sum_x + 32'(x_pos);
        sum_y <= sum_y + 32'(y_pos);
        cnt   <= cnt + 21'd1;
      end
      // Operands latch only from IDLE; a frame ending mid-divide is dropped.
      if (frame_end && state == IDLE) begin
        qx <= sum_x;
        qy <= sum_y;
        dv <= cnt;
      end else if (state == DIVIDE) begin
        qx   <= {qx[30:0], gx};
        qy   <= {qy[30:0], gy};
        rx   <= gx ? 21'(tx - {1'b0, dv}) : tx[20:0];
        ry   <= gy ? 21'(ty - {1'b0, dv}) : ty[20:0];
        step <= step + 5'd1;
      end
      if (state == CHECK) begin
        rx   <= '0;
        ry   <= '0;
        step <= '0;
        obj  <= ~no_obj;
      end
      centroid_valid <= state == DONE;
      if (state == DONE) begin
        found    <= obj;
        x_center <= obj ? qx[10:0] : '1;
        y_center <= obj ? qy[10:0] : '1;
      end
    end
endmodule

// File: tb/tb_vis_centroid_calc.sv
// tb_vis_centroid_calc: scoreboard bench on a reduced 128x64 frame.
module tb_vis_centroid_calc;
  localparam int W = 128, H = 64;
  logic clk = 0, rst = 1, de = 0, hsync = 0, vsync = 0, mask_in = 0;
  logic [10:0] x_center, y_center;
  logic found, centroid_valid;
  typedef struct {logic [10:0] x; logic [10:0] y; logic f; int due;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, cyc = 0, nvalid = 0, last_rise = 0;

  vis_centroid_calc #(.IMG_H(H), .IMG_W(W), .MIN_PIXELS(16)) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .mask_in(mask_in),
    .x_center(x_center), .y_center(y_center), .found(found), .centroid_valid(centroid_valid));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (centroid_valid === 1'b1) begin
      nvalid++;
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.due) begin fails++; $display("FAIL latency: got cycle %0d, required %0d", cyc, e.due); end
        checks++;
        if (x_center !== e.x) begin fails++; $display("FAIL x_center: got %0d, required %0d", x_center, e.x); end
        checks++;
        if (y_center !== e.y) begin fails++; $display("FAIL y_center: got %0d, required %0d", y_center, e.y); end
        checks++;
        if (found !== e.f) begin fails++; $display("FAIL found: got %0b, required %0b", found, e.f); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int nl, input int x0, input int x1, input int y0, input int y1, input bit push);
    longint sx = 0, sy = 0;
    int n = 0;
    exp_t e;
    for (int y = 0; y < nl; y++)
      for (int x = 0; x < W; x++) begin
        de = 1;
        mask_in = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
        if (mask_in) begin sx += x; sy += y; n++; end
        tick();
      end
    de = 0;
    mask_in = 0;
    repeat (2) tick();
    vsync = 1;
    last_rise = cyc;
    if (push) begin
      e.f = n != 0;
      e.x = n != 0 ? 11'(sx / n) : 11'h7ff;
      e.y = n != 0 ? 11'(sy / n) : 11'h7ff;
      e.due = cyc + (n != 0 ? 35 : 3);
      q.push_back(e);
    end
    repeat (3) tick();
    vsync = 0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 80 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d results pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++; if (x_center !== 11'h7ff) begin fails++; $display("FAIL rst_x: got %0d, required 2047", x_center); end
    checks++; if (y_center !== 11'h7ff) begin fails++; $display("FAIL rst_y: got %0d, required 2047", y_center); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL rst_found: got %0b, required 0", found); end
    checks++; if (centroid_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b, required 0", centroid_valid); end
    rst = 0;
    tick();
  endtask

  task automatic test_single_pixel();
    drive_frame(51, 100, 100, 50, 50, 1);
    wait_done("single");
  endtask

  task automatic test_rectangle();
    drive_frame(30, 10, 19, 20, 29, 1);
    wait_done("rect");
  endtask

  task automatic test_empty();
    drive_frame(1, 0, -1, 0, 0, 1);
    wait_done("empty");
  endtask

  task automatic test_full_frame();
    drive_frame(H, 0, W - 1, 0, H - 1, 1);
    wait_done("full");
  endtask

  task automatic test_reset_mid_divide();
    int nv;
    drive_frame(4, 7, 7, 3, 3, 0);
    while (cyc < last_rise + 13) tick();
    rst = 1;
    #1;
    checks++; if (x_center !== 11'h7ff) begin fails++; $display("FAIL mid_rst_x: got %0d, required 2047", x_center); end
    checks++; if (y_center !== 11'h7ff) begin fails++; $display("FAIL mid_rst_y: got %0d, required 2047", y_center); end
    checks++; if (found !== 1'b0) begin fails++; $display("FAIL mid_rst_found: got %0b, required 0", found); end
    checks++; if (centroid_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %0b, required 0", centroid_valid); end
    nv = nvalid;
    repeat (2) tick();
    rst = 0;
    repeat (40) tick();
    checks++; if (nvalid !== nv) begin fails++; $display("FAIL mid_rst_pulse: got %0d pulses, required 0", nvalid - nv); end
    drive_frame(3, 5, 5, 2, 2, 1);
    wait_done("after_rst");
  endtask

  task automatic test_back_to_back();
    int r;
    drive_frame(3, 9, 11, 1, 1, 1);
    r = last_rise;
    for (int i = 0; i < 10; i++) begin de = 1; mask_in = 1; tick(); end
    de = 0;
    mask_in = 0;
    while (cyc < r + 20) tick();
    vsync = 1;
    repeat (3) tick();
    vsync = 0;
    wait_done("b2b");
    repeat (10) tick();
    drive_frame(2, 5, 5, 1, 1, 1);
    wait_done("post_b2b");
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rectangle();
    test_empty();
    test_full_frame();
    test_reset_mid_divide();
    test_back_to_back();
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
